// File: rtl/uart_rx_fifo_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_ctrl_if
// Bundles every non-clock signal between the UART receive-side FIFO
// controller and its neighbours (receiver, UART_FIFO instance, register and
// interrupt block).
//   slave  : view of the controller itself (uart_rx_fifo_ctrl)
//   master : view of the surrounding environment driving the controller
// Signals:
//   fifo_en, fifo_clear, trig_sel, char_tick  : FCR / baud-generator controls
//   rx_valid, rx_data                         : byte from the receiver
//   fifo_push, fifo_data_in, fifo_pop,
//   fifo_data_out, fifo_count, fifo_reset     : FIFO push/pop/flush port
//   host_rd, host_data, lsr_rd                : RBR / LSR host accesses
//   data_ready, overrun_err                   : LSR status bits
//   int_rda, int_timeout                      : interrupt requests
// ---------------------------------------------------------------------------
interface uart_rx_fifo_ctrl_if #(
  parameter int DATA_W  = 8,
  parameter int COUNT_W = 5
);
  logic               fifo_en;
  logic               fifo_clear;
  logic [1:0]         trig_sel;
  logic               char_tick;
  logic               rx_valid;
  logic [DATA_W-1:0]  rx_data;
  logic               fifo_push;
  logic [DATA_W-1:0]  fifo_data_in;
  logic               fifo_pop;
  logic [DATA_W-1:0]  fifo_data_out;
  logic [COUNT_W-1:0] fifo_count;
  logic               fifo_reset;
  logic               host_rd;
  logic [DATA_W-1:0]  host_data;
  logic               data_ready;
  logic               overrun_err;
  logic               lsr_rd;
  logic               int_rda;
  logic               int_timeout;

  modport slave (
    input  fifo_en, fifo_clear, trig_sel, char_tick, rx_valid, rx_data,
           fifo_data_out, fifo_count, host_rd, lsr_rd,
    output fifo_push, fifo_data_in, fifo_pop, fifo_reset, host_data,
           data_ready, overrun_err, int_rda, int_timeout
  );

  modport master (
    output fifo_en, fifo_clear, trig_sel, char_tick, rx_valid, rx_data,
           fifo_data_out, fifo_count, host_rd, lsr_rd,
    input  fifo_push, fifo_data_in, fifo_pop, fifo_reset, host_data,
           data_ready, overrun_err, int_rda, int_timeout
  );
endinterface

// File: rtl/uart_rx_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_ctrl
// Receive-side controller for the 16-deep UART FIFO. Routes received bytes
// into the FIFO, pops the FIFO on host RBR reads, sequences a two-cycle FIFO
// flush, and raises the 16550-style trigger-level (RDA) and character-timeout
// interrupts.
// Ports:
//   clk   : system clock
//   reset : asynchronous reset, active-low
//   bus   : uart_rx_fifo_ctrl_if.slave, all data/control/status signals
// ---------------------------------------------------------------------------
module uart_rx_fifo_ctrl #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int COUNT_W  = 5,
  parameter int TO_CHARS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  uart_rx_fifo_ctrl_if.slave     bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CLR1 = 2'd1;
  localparam logic [1:0] ST_CLR2 = 2'd2;

  // Timeout counter needs at least 3 bits and must hold TO_CHARS.
  localparam int TO_W = ($clog2(TO_CHARS + 1) > 3) ? $clog2(TO_CHARS + 1) : 3;
  localparam logic [TO_W-1:0]    TO_MAX  = TO_W'(TO_CHARS);
  localparam logic [COUNT_W-1:0] DEPTH_C = COUNT_W'(DEPTH);
  localparam logic [COUNT_W-1:0] ZERO_C  = {COUNT_W{1'b0}};

  logic [1:0]         state_q, state_d;
  logic               fifo_reset_q;
  logic [DATA_W-1:0]  host_data_q;
  logic               overrun_q;
  logic               data_ready_q;
  logic               int_rda_q;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               int_to_q;

  logic               idle_s;
  logic               full_s;
  logic               empty_s;
  logic               push_s;
  logic               pop_s;
  logic               drop_s;
  logic               to_zero_s;
  logic [COUNT_W-1:0] trig_lvl_s;

  assign idle_s  = (state_q == ST_IDLE);
  // Full is judged on the current count only; a same-cycle pop does not
  // make room for the incoming byte.
  assign full_s  = (bus.fifo_count >= DEPTH_C);
  assign empty_s = (bus.fifo_count == ZERO_C);
  assign push_s  = idle_s & bus.rx_valid & ~full_s;
  assign pop_s   = idle_s & bus.host_rd & ~empty_s;
  // Bytes arriving during a flush are discarded silently, not as overruns.
  assign drop_s  = idle_s & bus.rx_valid & full_s;

  // Flush sequencing: a clear request (re)starts the two-cycle flush.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.fifo_clear) state_d = ST_CLR1;
        else                state_d = ST_IDLE;
      end
      ST_CLR1: begin
        if (bus.fifo_clear) state_d = ST_CLR1;
        else                state_d = ST_CLR2;
      end
      ST_CLR2: begin
        if (bus.fifo_clear) state_d = ST_CLR1;
        else                state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Trigger level decode; 16450 mode behaves as a one-byte trigger.
  always_comb begin
    trig_lvl_s = COUNT_W'(1);
    if (!bus.fifo_en) begin
      trig_lvl_s = COUNT_W'(1);
    end else begin
      case (bus.trig_sel)
        2'b00:   trig_lvl_s = COUNT_W'(1);
        2'b01:   trig_lvl_s = COUNT_W'(4);
        2'b10:   trig_lvl_s = COUNT_W'(8);
        2'b11:   trig_lvl_s = COUNT_W'(14);
        default: trig_lvl_s = COUNT_W'(1);
      endcase
    end
  end

  // Any FIFO activity, an empty FIFO, 16450 mode or a flush (including the
  // cycle that enters it) restarts the character-timeout measurement.
  assign to_zero_s = push_s | pop_s | empty_s | ~bus.fifo_en |
                     (state_q != ST_IDLE) | (state_d != ST_IDLE);

  // Timeout counter next value: saturating count of idle character times.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (to_zero_s) begin
      to_cnt_d = {TO_W{1'b0}};
    end else if (bus.char_tick && (to_cnt_q != TO_MAX)) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end else begin
      to_cnt_d = to_cnt_q;
    end
  end

  // FSM state and registered flush strobe (high exactly while in CLR1/CLR2).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      fifo_reset_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fifo_reset_q <= (state_d != ST_IDLE);
    end
  end

  // RBR holding register and LSR status bits; overrun set wins over clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      host_data_q  <= {DATA_W{1'b0}};
      overrun_q    <= 1'b0;
      data_ready_q <= 1'b0;
    end else begin
      if (pop_s) host_data_q <= bus.fifo_data_out;
      else       host_data_q <= host_data_q;
      if (drop_s)          overrun_q <= 1'b1;
      else if (bus.lsr_rd) overrun_q <= 1'b0;
      else                 overrun_q <= overrun_q;
      data_ready_q <= ~empty_s;
    end
  end

  // Interrupt requests: trigger-level compare and character timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      int_rda_q <= 1'b0;
      to_cnt_q  <= {TO_W{1'b0}};
      int_to_q  <= 1'b0;
    end else begin
      int_rda_q <= (bus.fifo_count >= trig_lvl_s);
      to_cnt_q  <= to_cnt_d;
      int_to_q  <= (to_cnt_d == TO_MAX);
    end
  end

  assign bus.fifo_push    = push_s;
  assign bus.fifo_data_in = bus.rx_data;
  assign bus.fifo_pop     = pop_s;
  assign bus.fifo_reset   = fifo_reset_q;
  assign bus.host_data    = host_data_q;
  assign bus.data_ready   = data_ready_q;
  assign bus.overrun_err  = overrun_q;
  assign bus.int_rda      = int_rda_q;
  assign bus.int_timeout  = int_to_q;

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo_ctrl
// Directed bench for uart_rx_fifo_ctrl: a table of single-cycle vectors for
// trigger level / push / pop behaviour, plus hand-written sequences for
// overrun, character timeout, flush and reset. A small 16-entry FIFO
// stands in for the UART_FIFO instance.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo_ctrl;
  logic clk;
  logic reset;

  uart_rx_fifo_ctrl_if #(.DATA_W(8), .COUNT_W(5)) bus ();

  uart_rx_fifo_ctrl #(.DATA_W(8), .DEPTH(16), .COUNT_W(5), .TO_CHARS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO stand-in: storage, pointers and count, flushed by fifo_reset.
  logic [7:0] mem [16];
  logic [3:0] wr_p, rd_p;
  logic [4:0] cnt;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_p <= 4'd0; rd_p <= 4'd0; cnt <= 5'd0;
    end else if (bus.fifo_reset) begin
      wr_p <= 4'd0; rd_p <= 4'd0; cnt <= 5'd0;
    end else begin
      if (bus.fifo_push) wr_p <= wr_p + 4'd1;
      if (bus.fifo_pop)  rd_p <= rd_p + 4'd1;
      cnt <= cnt + 5'(bus.fifo_push) - 5'(bus.fifo_pop);
    end
  end

  always @(posedge clk) begin
    if (reset && !bus.fifo_reset && bus.fifo_push) mem[wr_p] <= bus.fifo_data_in;
  end

  assign bus.fifo_count    = cnt;
  assign bus.fifo_data_out = mem[rd_p];

  int n_cmp = 0;
  int n_err = 0;
  logic       s_push, s_pop;
  logic [7:0] s_din;

  typedef struct packed {
    logic       en;
    logic [1:0] trig;
    logic       rxv;
    logic [7:0] rxd;
    logic       rd;
    logic       exp_push;
    logic       exp_pop;
    logic [7:0] exp_hd;
    logic       exp_dr;
    logic       exp_rda;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // One clock cycle: drive inputs at negedge, sample strobes, pass the edge.
  task automatic cyc(input logic rxv, input logic [7:0] rxd, input logic rd,
                     input logic lsr, input logic clr, input logic tick);
    @(negedge clk);
    bus.rx_valid   = rxv;
    bus.rx_data    = rxd;
    bus.host_rd    = rd;
    bus.lsr_rd     = lsr;
    bus.fifo_clear = clr;
    bus.char_tick  = tick;
    #1;
    s_push = bus.fifo_push;
    s_pop  = bus.fifo_pop;
    s_din  = bus.fifo_data_in;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            en  trig   rxv   rxd    rd    push  pop   hd     dr    rda
    tbl[0]  = '{1'b1, 2'b01, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 2'b01, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 2'b01, 1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 2'b01, 1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 2'b01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 2'b01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 2'b01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 2'b11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 2'b11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 2'b10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 2'b10, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 2'b10, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 2'b10, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h03, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 2'b10, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0};

    // Power-on reset
    reset = 1'b0;
    bus.fifo_en = 1'b1; bus.trig_sel = 2'b01; bus.fifo_clear = 1'b0;
    bus.char_tick = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
    bus.host_rd = 1'b0; bus.lsr_rd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.fifo_reset", 32'(bus.fifo_reset), 32'd0);
    chk("rst.host_data", 32'(bus.host_data), 32'd0);
    chk("rst.overrun", 32'(bus.overrun_err), 32'd0);
    chk("rst.int_rda", 32'(bus.int_rda), 32'd0);
    chk("rst.int_timeout", 32'(bus.int_timeout), 32'd0);
    chk("rst.data_ready", 32'(bus.data_ready), 32'd0);
    chk("rst.push", 32'(bus.fifo_push), 32'd0);
    chk("rst.pop", 32'(bus.fifo_pop), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Table: trigger level 4, trigger decode, reads and empty read
    for (int i = 0; i < 15; i++) begin
      bus.fifo_en  = tbl[i].en;
      bus.trig_sel = tbl[i].trig;
      cyc(tbl[i].rxv, tbl[i].rxd, tbl[i].rd, 1'b0, 1'b0, 1'b0);
      chk($sformatf("tbl[%0d].push", i), 32'(s_push), 32'(tbl[i].exp_push));
      chk($sformatf("tbl[%0d].pop", i), 32'(s_pop), 32'(tbl[i].exp_pop));
      chk($sformatf("tbl[%0d].host_data", i), 32'(bus.host_data), 32'(tbl[i].exp_hd));
      chk($sformatf("tbl[%0d].data_ready", i), 32'(bus.data_ready), 32'(tbl[i].exp_dr));
      chk($sformatf("tbl[%0d].int_rda", i), 32'(bus.int_rda), 32'(tbl[i].exp_rda));
      if (tbl[i].rxv) chk($sformatf("tbl[%0d].data_in", i), 32'(s_din), 32'(tbl[i].rxd));
    end

    // Overrun: 17 bytes into a 16-deep FIFO
    bus.fifo_en = 1'b1; bus.trig_sel = 2'b00;
    for (int i = 0; i < 17; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("fill[%0d].push", i), 32'(s_push), (i < 16) ? 32'd1 : 32'd0);
      chk($sformatf("fill[%0d].overrun", i), 32'(bus.overrun_err), (i < 16) ? 32'd0 : 32'd1);
    end
    chk("full.int_rda", 32'(bus.int_rda), 32'd1);
    idle();
    chk("ovr.sticky", 32'(bus.overrun_err), 32'd1);
    cyc(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("ovr.setwins.push", 32'(s_push), 32'd0);
    chk("ovr.setwins", 32'(bus.overrun_err), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("ovr.lsr_clear", 32'(bus.overrun_err), 32'd0);
    cyc(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("fullrw.push", 32'(s_push), 32'd0);
    chk("fullrw.pop", 32'(s_pop), 32'd1);
    chk("fullrw.overrun", 32'(bus.overrun_err), 32'd1);
    chk("fullrw.host_data", 32'(bus.host_data), 32'd0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int j = 1; j < 16; j++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      chk($sformatf("drain[%0d].pop", j), 32'(s_pop), 32'd1);
      chk($sformatf("drain[%0d].host_data", j), 32'(bus.host_data), 32'(j));
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("underrun.pop", 32'(s_pop), 32'd0);
    chk("underrun.host_data", 32'(bus.host_data), 32'h0F);
    chk("underrun.overrun", 32'(bus.overrun_err), 32'd0);

    // Character timeout
    cyc(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("to1.tick%0d", k), 32'(bus.int_timeout), (k == 4) ? 32'd1 : 32'd0);
    end
    tick();
    chk("to1.saturate", 32'(bus.int_timeout), 32'd1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("to.rd_clear", 32'(bus.int_timeout), 32'd0);
    chk("to.rd_data", 32'(bus.host_data), 32'h11);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("to2.tick%0d", k), 32'(bus.int_timeout), (k == 4) ? 32'd1 : 32'd0);
    end
    cyc(1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("pushpop.push", 32'(s_push), 32'd1);
    chk("pushpop.pop", 32'(s_pop), 32'd1);
    chk("pushpop.host_data", 32'(bus.host_data), 32'h22);
    chk("pushpop.int_timeout", 32'(bus.int_timeout), 32'd0);
    bus.fifo_en = 1'b0;
    repeat (4) tick();
    chk("to.16450_mode", 32'(bus.int_timeout), 32'd0);
    bus.fifo_en = 1'b1;

    // Flush with 5 bytes queued and the timeout interrupt pending
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) tick();
    chk("clr.pre_timeout", 32'(bus.int_timeout), 32'd1);
    chk("clr.pre_reset", 32'(bus.fifo_reset), 32'd0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("clr.c1.fifo_reset", 32'(bus.fifo_reset), 32'd1);
    chk("clr.c1.int_timeout", 32'(bus.int_timeout), 32'd0);
    cyc(1'b1, 8'h99, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("clr.rx_push", 32'(s_push), 32'd0);
    chk("clr.rd_pop", 32'(s_pop), 32'd0);
    chk("clr.c2.fifo_reset", 32'(bus.fifo_reset), 32'd1);
    chk("clr.overrun", 32'(bus.overrun_err), 32'd0);
    chk("clr.host_data", 32'(bus.host_data), 32'h22);
    chk("clr.c2.int_timeout", 32'(bus.int_timeout), 32'd0);
    idle();
    chk("clr.done", 32'(bus.fifo_reset), 32'd0);
    chk("clr.data_ready", 32'(bus.data_ready), 32'd0);
    chk("clr.int_rda", 32'(bus.int_rda), 32'd0);

    // Clear request inside CLR1 restarts the flush
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    chk("restart.still_reset", 32'(bus.fifo_reset), 32'd1);
    idle();
    chk("restart.done", 32'(bus.fifo_reset), 32'd0);

    // Asynchronous reset in the middle of CLR1
    cyc(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'hC2, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) tick();
    chk("prerst.int_timeout", 32'(bus.int_timeout), 32'd1);
    chk("prerst.host_data", 32'(bus.host_data), 32'hC1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("prerst.fifo_reset", 32'(bus.fifo_reset), 32'd1);
    chk("prerst.data_ready", 32'(bus.data_ready), 32'd1);
    #2;
    bus.fifo_clear = 1'b0; bus.char_tick = 1'b0;
    reset = 1'b0;
    #1;
    chk("midrst.fifo_reset", 32'(bus.fifo_reset), 32'd0);
    chk("midrst.host_data", 32'(bus.host_data), 32'd0);
    chk("midrst.overrun", 32'(bus.overrun_err), 32'd0);
    chk("midrst.int_rda", 32'(bus.int_rda), 32'd0);
    chk("midrst.int_timeout", 32'(bus.int_timeout), 32'd0);
    chk("midrst.data_ready", 32'(bus.data_ready), 32'd0);
    chk("midrst.push", 32'(bus.fifo_push), 32'd0);
    chk("midrst.pop", 32'(bus.fifo_pop), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    cyc(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("postrst.push", 32'(s_push), 32'd1);
    chk("postrst.data_in", 32'(s_din), 32'h5A);
    chk("postrst.fifo_reset", 32'(bus.fifo_reset), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
